// File: rtl/aes_encrypt_iterative_pkg.sv
// Shared AES-128 constants, FSM type and GF(2^8) helpers for the iterative encryption core.
// Byte k of a 128-bit block lives at bits [127-8k -: 8]; each column is four consecutive bytes.
package aes_encrypt_iterative_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = sub_word(s[32*i +: 32]);
    return r;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// Combinational AES-128 key schedule step: derives the next round key from the current one.
module aes_key_round
  import aes_encrypt_iterative_pkg::*;
(
  input  logic [127:0] rkey,
  input  logic [7:0]   rcon,
  output logic [127:0] rkey_next
);

  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;

  assign w0 = rkey[127:96];
  assign w1 = rkey[95:64];
  assign w2 = rkey[63:32];
  assign w3 = rkey[31:0];

  assign w4 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign rkey_next = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_encrypt_iterative.sv
// Iterative AES-128 encryption core: one full round per clock with on-the-fly key expansion,
// valid/ready handshakes on the plaintext and ciphertext sides.
module aes_encrypt_iterative
  import aes_encrypt_iterative_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] plaintext,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ciphertext
);

  fsm_t         fsm, fsm_next;
  logic [127:0] blk;
  logic [127:0] rkey;
  logic [127:0] rkey_next;
  logic [127:0] ct_q;
  logic [3:0]   round;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         last_round;
  logic [127:0] shifted;

  aes_key_round u_key_round (
    .rkey      (rkey),
    .rcon      (rcon_of(round)),
    .rkey_next (rkey_next)
  );

  assign last_round = (round == 4'(NR));
  assign shifted    = shift_rows(sub_bytes(blk));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (in_valid && in_ready_q) fsm_next = BUSY;
      BUSY:    if (last_round) fsm_next = DONE;
      DONE:    if (out_ready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // in_ready is registered so it stays low during reset and rises on the first clock in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk         <= '0;
      rkey        <= '0;
      round       <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      in_ready_q <= (fsm_next == IDLE);
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            blk   <= plaintext ^ key;
            rkey  <= key;
            round <= 4'd1;
          end
        end
        BUSY: begin
          rkey <= rkey_next;
          if (last_round) begin
            ct_q        <= shifted ^ rkey_next;
            out_valid_q <= 1'b1;
            round       <= '0;
          end else begin
            blk   <= mix_columns(shifted) ^ rkey_next;
            round <= round + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// Self-checking bench for aes_encrypt_iterative: FIPS-197 vectors, handshake timing and a
// random sweep against a byte-level AES reference model whose S-box is derived from GF(2^8).
module tb_aes_encrypt_iterative;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] plaintext;
  logic [0:127] key;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] ciphertext;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0] sb [256];

  aes_encrypt_iterative dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // GF(2^8) multiply by shift-and-add over the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic buildSbox();
    logic [7:0] x, inv, s;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(x, 8'(j)) == 8'h01) inv = 8'(j);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[i] = s;
    end
  endtask

  function automatic logic [127:0] aesModel(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tw;
    logic [7:0]  rc;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int j = 0; j < 16; j++) s[j] = sb[s[j]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
      for (int j = 0; j < 16; j++) s[j] = t[j];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int rw = 0; rw < 4; rw++)
            t[4*c+rw] = gmul(s[4*c+rw], 8'h02) ^ gmul(s[4*c+(rw+1)%4], 8'h03)
                      ^ s[4*c+(rw+2)%4] ^ s[4*c+(rw+3)%4];
        for (int j = 0; j < 16; j++) s[j] = t[j];
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rnd + j/4][31-8*(j%4) -: 8];
    end
    r = '0;
    for (int j = 0; j < 16; j++) r[127-8*j -: 8] = s[j];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for in_ready (bounded), then presents one block for exactly the accept edge.
  task automatic applyStimulus(input logic [127:0] p, input logic [127:0] k);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("accept_ready", 128'(in_ready), 128'(1));
    plaintext = p;
    key = k;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic awaitOutput(input string tag, input logic [127:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_latency"}, 128'(n), 128'(10));
    checkOutput({tag, "_ct"}, ciphertext, exp);
  endtask

  task automatic releaseOutput(input int hold, input logic [127:0] exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 128'(out_valid), 128'(1));
      checkOutput("hold_ct", ciphertext, exp);
      checkOutput("hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_valid", 128'(out_valid), 128'(0));
    checkOutput("release_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] kb, pb, kc, pc, ctb, ctc, p1, k1, p2, k2, pr, kr, e1, e2;
    int n;
    logic seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = '0; key = '0;
    buildSbox();

    kb = 128'h2b7e151628aed2a6abf7158809cf4f3c; pb = 128'h3243f6a8885a308d313198a2e0370734;
    ctb = 128'h3925841d02dc09fbdc118597196a0b32;
    kc = 128'h000102030405060708090a0b0c0d0e0f; pc = 128'h00112233445566778899aabbccddeeff;
    ctc = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_ct", ciphertext, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", 128'(in_ready), 128'(1));

    // App. B with 20 cycles of backpressure
    applyStimulus(pb, kb);
    checkOutput("busy_in_ready", 128'(in_ready), 128'(0));
    awaitOutput("appB", ctb);
    releaseOutput(20, ctb);

    // App. C.1
    applyStimulus(pc, kc);
    awaitOutput("appC", ctc);
    releaseOutput(0, ctc);

    // Input stability: scramble inputs and in_valid while the block is in flight
    applyStimulus(pb, kb);
    n = 0;
    while (!out_valid && n < 30) begin
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
      if (!out_valid) checkOutput("stab_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    checkOutput("stab_latency", 128'(n), 128'(10));
    checkOutput("stab_ct", ciphertext, ctb);
    releaseOutput(2, ctb);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("stab_no_second", 128'(seen), 128'(0));

    // Asynchronous reset in the middle of round 5
    applyStimulus(pc, kc);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("midrst_in_ready", 128'(in_ready), 128'(0));
    checkOutput("midrst_ct", ciphertext, 128'h0);
    @(posedge clk); #1;
    checkOutput("midrst_in_ready_hold", 128'(in_ready), 128'(0));
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("midrst_no_ct", 128'(seen), 128'(0));
    applyStimulus(pc, kc);
    awaitOutput("post_rst_appC", ctc);
    releaseOutput(1, ctc);

    // Back-to-back with out_ready tied high
    p1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    p2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    e1 = aesModel(k1, p1);
    e2 = aesModel(k2, p2);
    out_ready = 1'b1;
    applyStimulus(p1, k1);
    n = acc_cyc;
    awaitOutput("b2b_first", e1);
    applyStimulus(p2, k2);
    checkOutput("b2b_spacing", 128'(acc_cyc - n), 128'(12));
    awaitOutput("b2b_second", e2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("b2b_drained", 128'(out_valid), 128'(0));

    // Random sweep against the reference model
    for (int i = 0; i < 8; i++) begin
      pr = {$urandom(), $urandom(), $urandom(), $urandom()};
      kr = {$urandom(), $urandom(), $urandom(), $urandom()};
      e1 = aesModel(kr, pr);
      applyStimulus(pr, kr);
      awaitOutput("rand", e1);
      releaseOutput(int'($urandom_range(0, 3)), e1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
